// File: rtl/divider_pkg.sv
// Shared widths, state encoding and counter type for the restoring divider.
package divider_pkg;

    localparam int unsigned DATA_LENGTH = 16;
    localparam int unsigned QUO_W       = 2 * DATA_LENGTH;
    localparam int unsigned REM_W       = DATA_LENGTH + 1;
    localparam int unsigned CNT_W       = $clog2(QUO_W) + 1;

    typedef enum logic [1:0] {
        idle    = 2'd0,
        init    = 2'd1,
        compute = 2'd2,
        finish  = 2'd3
    } div_state_t;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift {rem, quo} left, then conditionally subtract the divisor.
module divider_step
    import divider_pkg::*;
(
    input  logic [REM_W-1:0]       rem,
    input  logic [QUO_W-1:0]       quo,
    input  logic [DATA_LENGTH-1:0] divisor,
    output logic [REM_W-1:0]       rem_next,
    output logic [QUO_W-1:0]       quo_next
);

    logic [REM_W:0] shifted;
    logic [REM_W:0] div_ext;
    logic [REM_W:0] diff;
    logic           ge;

    // Compare on one extra bit so the shifted-out remainder MSB is never lost.
    always_comb begin
        shifted  = {rem, quo[QUO_W-1]};
        div_ext  = (REM_W + 1)'(divisor);
        diff     = shifted - div_ext;
        ge       = (shifted >= div_ext);
        rem_next = ge ? REM_W'(diff) : REM_W'(shifted);
        quo_next = {quo[QUO_W-2:0], ge};
    end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider, one quotient bit per cycle, with start/busy/finish handshake.
module divider
    import divider_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [QUO_W-1:0]       indata_n_i,
    input  logic [DATA_LENGTH-1:0] indata_d_i,
    output logic                   busy_o,
    output logic                   finish_o,
    output logic                   div_by_zero_o,
    output logic [QUO_W-1:0]       outdata_q_o,
    output logic [DATA_LENGTH-1:0] outdata_r_o
);

    div_state_t             state_q;
    div_state_t             state_d;
    logic [QUO_W-1:0]       quo_q;
    logic [REM_W-1:0]       rem_q;
    logic [DATA_LENGTH-1:0] div_q;
    cnt_t                   cnt_q;
    logic [QUO_W-1:0]       quo_step;
    logic [REM_W-1:0]       rem_step;
    logic                   busy_d;
    logic                   finish_d;
    logic                   d_zero;

    assign d_zero = (indata_d_i == '0);

    divider_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (div_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= idle;
        else       state_q <= state_d;
    end

    // Counter is checked before its decrement, so 1 means the last step is in flight.
    always_comb begin
        state_d = idle;
        case (state_q)
            idle:    state_d = start_i ? init : idle;
            init:    state_d = d_zero ? finish : compute;
            compute: state_d = (cnt_q == cnt_t'(1)) ? finish : compute;
            finish:  state_d = idle;
            default: state_d = idle;
        endcase
    end

    // Status flags are decoded from the upcoming state and registered.
    always_comb begin
        busy_d   = (state_d == init) || (state_d == compute);
        finish_d = (state_d == finish);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_o        <= 1'b0;
            finish_o      <= 1'b0;
            div_by_zero_o <= 1'b0;
            quo_q         <= '0;
            rem_q         <= '0;
            div_q         <= '0;
            cnt_q         <= '0;
        end else begin
            busy_o   <= busy_d;
            finish_o <= finish_d;
            case (state_q)
                init: begin
                    // A zero divisor skips compute and presents the saturated result directly.
                    quo_q         <= d_zero ? '1 : indata_n_i;
                    rem_q         <= d_zero ? REM_W'(indata_n_i[DATA_LENGTH-1:0]) : '0;
                    div_q         <= indata_d_i;
                    cnt_q         <= cnt_t'(QUO_W);
                    div_by_zero_o <= d_zero;
                end
                compute: begin
                    quo_q <= quo_step;
                    rem_q <= rem_step;
                    cnt_q <= cnt_q - cnt_t'(1);
                end
                default: ;
            endcase
        end
    end

    assign outdata_q_o = quo_q;
    assign outdata_r_o = rem_q[DATA_LENGTH-1:0];

endmodule

// File: tb/tb_divider.sv
// Randomized and directed bench for divider, checked against plain integer division.
module tb_divider;
    import divider_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_i;
    logic                   start_i;
    logic [QUO_W-1:0]       indata_n_i;
    logic [DATA_LENGTH-1:0] indata_d_i;
    logic                   busy_o;
    logic                   finish_o;
    logic                   div_by_zero_o;
    logic [QUO_W-1:0]       outdata_q_o;
    logic [DATA_LENGTH-1:0] outdata_r_o;

    int errors = 0;
    int checks = 0;

    localparam int LAT     = 2 * DATA_LENGTH + 2;
    localparam int PERIOD  = 2 * DATA_LENGTH + 3;

    always #5 clk = ~clk;

    divider dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .indata_n_i    (indata_n_i),
        .indata_d_i    (indata_d_i),
        .busy_o        (busy_o),
        .finish_o      (finish_o),
        .div_by_zero_o (div_by_zero_o),
        .outdata_q_o   (outdata_q_o),
        .outdata_r_o   (outdata_r_o)
    );

    // Reference: quotient/remainder from integer arithmetic, saturated result for divide by zero.
    function automatic logic [QUO_W-1:0] ref_q(input logic [QUO_W-1:0] n, input logic [DATA_LENGTH-1:0] d);
        if (d == 0) return '1;
        return n / QUO_W'(d);
    endfunction

    function automatic logic [DATA_LENGTH-1:0] ref_r(input logic [QUO_W-1:0] n, input logic [DATA_LENGTH-1:0] d);
        logic [QUO_W-1:0] m;
        if (d == 0) return n[DATA_LENGTH-1:0];
        m = n % QUO_W'(d);
        return m[DATA_LENGTH-1:0];
    endfunction

    // Launches one division and observes it; fin_cyc counts cycles after the sampling edge (-1 on timeout).
    task automatic run_div(input logic [QUO_W-1:0] n, input logic [DATA_LENGTH-1:0] d,
                           output int fin_cyc, output int busy_cyc, output logic ovl,
                           output logic [QUO_W-1:0] q, output logic [DATA_LENGTH-1:0] r,
                           output logic dbz, output logic fin_after);
        @(negedge clk);
        indata_n_i = n;
        indata_d_i = d;
        start_i    = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        fin_cyc  = -1;
        busy_cyc = 0;
        ovl      = 1'b0;
        q        = '0;
        r        = '0;
        dbz      = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (busy_o) busy_cyc++;
            if (busy_o && finish_o) ovl = 1'b1;
            if (finish_o) begin
                fin_cyc = c;
                q       = outdata_q_o;
                r       = outdata_r_o;
                dbz     = div_by_zero_o;
                break;
            end
        end
        @(negedge clk);
        fin_after = finish_o;
    endtask

    task automatic test_reset;
        int fins;
        int busys;
        rst_i = 1'b1;
        start_i = 1'b0;
        indata_n_i = '0;
        indata_d_i = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (finish_o !== 1'b0)      begin errors++; $display("FAIL reset_finish got=%b exp=0", finish_o); end
        checks++; if (div_by_zero_o !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero_o); end
        checks++; if (outdata_q_o !== '0)     begin errors++; $display("FAIL reset_q got=%h exp=0", outdata_q_o); end
        checks++; if (outdata_r_o !== '0)     begin errors++; $display("FAIL reset_r got=%h exp=0", outdata_r_o); end
        rst_i = 1'b0;

        // Mid-run reset: start a division, then abort it.
        @(negedge clk);
        indata_n_i = 32'h1234_5678;
        indata_d_i = 16'h0003;
        start_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0)    begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy_o); end
        checks++; if (outdata_q_o !== '0) begin errors++; $display("FAIL midreset_q got=%h exp=0", outdata_q_o); end
        checks++; if (outdata_r_o !== '0) begin errors++; $display("FAIL midreset_r got=%h exp=0", outdata_r_o); end
        @(negedge clk);
        rst_i = 1'b0;
        fins  = 0;
        busys = 0;
        repeat (50) begin
            @(negedge clk);
            if (finish_o) fins++;
            if (busy_o) busys++;
        end
        checks++; if (fins !== 0)  begin errors++; $display("FAIL midreset_no_finish got=%0d exp=0", fins); end
        checks++; if (busys !== 0) begin errors++; $display("FAIL midreset_idle got=%0d exp=0", busys); end
    endtask

    task automatic test_directed;
        logic [QUO_W-1:0]       tn [5];
        logic [DATA_LENGTH-1:0] td [5];
        logic [QUO_W-1:0]       tq [5];
        logic [DATA_LENGTH-1:0] tr [5];
        int fc, bc;
        logic ovl, dbz, fa;
        logic [QUO_W-1:0] q;
        logic [DATA_LENGTH-1:0] r;
        tn = '{32'h0000_0064, 32'h0000_9088, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0005};
        td = '{16'h0007,      16'h0025,      16'hFFFF,      16'h0001,      16'hFFFF};
        tq = '{32'h0000_000E, 32'h0000_03E8, 32'h0001_0001, 32'h1234_5678, 32'h0000_0000};
        tr = '{16'h0002,      16'h0000,      16'h0000,      16'h0000,      16'h0005};
        for (int i = 0; i < 5; i++) begin
            run_div(tn[i], td[i], fc, bc, ovl, q, r, dbz, fa);
            checks++; if (q !== tq[i])  begin errors++; $display("FAIL dir%0d_q got=%h exp=%h", i, q, tq[i]); end
            checks++; if (r !== tr[i])  begin errors++; $display("FAIL dir%0d_r got=%h exp=%h", i, r, tr[i]); end
            checks++; if (fc !== LAT)   begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, fc, LAT); end
            checks++; if (bc !== LAT-1) begin errors++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bc, LAT-1); end
            checks++; if (ovl !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_finish_overlap got=%b exp=0", i, ovl); end
            checks++; if (fa !== 1'b0)  begin errors++; $display("FAIL dir%0d_finish_width got=%b exp=0", i, fa); end
            checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL dir%0d_dbz got=%b exp=0", i, dbz); end
        end
    endtask

    task automatic test_div_by_zero;
        int fc, bc;
        logic ovl, dbz, fa;
        logic [QUO_W-1:0] q;
        logic [DATA_LENGTH-1:0] r;
        run_div(32'hDEAD_BEEF, 16'h0000, fc, bc, ovl, q, r, dbz, fa);
        checks++; if (fc !== 2)              begin errors++; $display("FAIL dbz_latency got=%0d exp=2", fc); end
        checks++; if (dbz !== 1'b1)          begin errors++; $display("FAIL dbz_flag got=%b exp=1", dbz); end
        checks++; if (q !== 32'hFFFF_FFFF)   begin errors++; $display("FAIL dbz_q got=%h exp=ffffffff", q); end
        checks++; if (r !== 16'hBEEF)        begin errors++; $display("FAIL dbz_r got=%h exp=beef", r); end
        checks++; if (fa !== 1'b0)           begin errors++; $display("FAIL dbz_finish_width got=%b exp=0", fa); end
        checks++; if (div_by_zero_o !== 1'b1) begin errors++; $display("FAIL dbz_held got=%b exp=1", div_by_zero_o); end
        run_div(32'd1000, 16'd10, fc, bc, ovl, q, r, dbz, fa);
        checks++; if (dbz !== 1'b0)    begin errors++; $display("FAIL dbz_cleared got=%b exp=0", dbz); end
        checks++; if (q !== 32'd100)   begin errors++; $display("FAIL dbz_next_q got=%h exp=64", q); end
        // Reset while the flag is held in idle must clear it.
        run_div(32'h0000_1234, 16'h0000, fc, bc, ovl, q, r, dbz, fa);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        checks++; if (div_by_zero_o !== 1'b0) begin errors++; $display("FAIL dbz_reset got=%b exp=0", div_by_zero_o); end
    endtask

    task automatic test_random;
        int fc, bc;
        logic ovl, dbz, fa;
        logic [QUO_W-1:0] q, n;
        logic [DATA_LENGTH-1:0] r, d;
        for (int i = 0; i < 24; i++) begin
            n = QUO_W'($urandom);
            case (i % 4)
                0: d = DATA_LENGTH'($urandom_range(1, 15));
                1: d = DATA_LENGTH'($urandom_range(0, 65535));
                2: begin d = DATA_LENGTH'($urandom_range(1, 65535)); n = QUO_W'(DATA_LENGTH'($urandom)) * QUO_W'(d); end
                default: d = (i % 8 == 7) ? '0 : DATA_LENGTH'($urandom_range(256, 65535));
            endcase
            run_div(n, d, fc, bc, ovl, q, r, dbz, fa);
            checks++; if (q !== ref_q(n, d)) begin errors++; $display("FAIL rnd%0d_q n=%h d=%h got=%h exp=%h", i, n, d, q, ref_q(n, d)); end
            checks++; if (r !== ref_r(n, d)) begin errors++; $display("FAIL rnd%0d_r n=%h d=%h got=%h exp=%h", i, n, d, r, ref_r(n, d)); end
            checks++; if (dbz !== (d == 0))  begin errors++; $display("FAIL rnd%0d_dbz got=%b exp=%b", i, dbz, (d == 0)); end
            checks++; if (fc !== ((d == 0) ? 2 : LAT)) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, fc, (d == 0) ? 2 : LAT); end
        end
    endtask

    task automatic test_back_to_back;
        int fin_at [$];
        logic [QUO_W-1:0] qs [$];
        logic [DATA_LENGTH-1:0] rs [$];
        logic [QUO_W-1:0] n;
        logic [DATA_LENGTH-1:0] d;
        n = 32'h00AB_CDEF;
        d = 16'h0123;
        @(negedge clk);
        indata_n_i = n;
        indata_d_i = d;
        start_i    = 1'b1;
        for (int c = 1; c <= 4 * PERIOD && fin_at.size() < 3; c++) begin
            @(negedge clk);
            if (finish_o) begin
                fin_at.push_back(c);
                qs.push_back(outdata_q_o);
                rs.push_back(outdata_r_o);
            end
        end
        start_i = 1'b0;
        checks++; if (fin_at.size() !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", fin_at.size()); end
        for (int i = 0; i < fin_at.size(); i++) begin
            checks++; if (fin_at[i] !== LAT + i * PERIOD) begin errors++; $display("FAIL b2b%0d_time got=%0d exp=%0d", i, fin_at[i], LAT + i * PERIOD); end
            checks++; if (qs[i] !== ref_q(n, d)) begin errors++; $display("FAIL b2b%0d_q got=%h exp=%h", i, qs[i], ref_q(n, d)); end
            checks++; if (rs[i] !== ref_r(n, d)) begin errors++; $display("FAIL b2b%0d_r got=%h exp=%h", i, rs[i], ref_r(n, d)); end
        end
        repeat (2 * PERIOD) @(negedge clk);
    endtask

    task automatic test_start_ignored;
        int fc;
        int busys;
        logic [QUO_W-1:0] q;
        logic [DATA_LENGTH-1:0] r;
        fc = -1;
        q  = '0;
        r  = '0;
        @(negedge clk);
        indata_n_i = 32'd1000;
        indata_d_i = 16'd7;
        start_i    = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) start_i = 1'b0;
            if (c == 10) begin
                start_i    = 1'b1;
                indata_n_i = 32'hFFFF_0000;
                indata_d_i = 16'h0001;
            end
            if (c == 11) start_i = 1'b0;
            if (finish_o) begin
                fc = c;
                q  = outdata_q_o;
                r  = outdata_r_o;
                break;
            end
        end
        checks++; if (fc !== LAT)      begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", fc, LAT); end
        checks++; if (q !== 32'd142)   begin errors++; $display("FAIL ignore_q got=%h exp=8e", q); end
        checks++; if (r !== 16'd6)     begin errors++; $display("FAIL ignore_r got=%h exp=6", r); end
        busys = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy_o) busys++;
        end
        checks++; if (busys !== 0) begin errors++; $display("FAIL ignore_not_queued got=%0d exp=0", busys); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_random();
        test_back_to_back();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
